// File: rtl/mlp_load_sequencer.sv
// Streams input and weight words from source memory to the accelerator load port.
// The input beats and weight beats of layer 0 are interleaved per row; each later layer carries weight beats only.
module mlp_load_sequencer #(
  parameter int NUM_LAYERS = 8,
  parameter int ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stall_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [31:0]       mem_rd_data_i,
  output logic              load_en_o,
  output logic [31:0]       load_payload_o,
  output logic              load_type_o,
  output logic [3:0]        input_load_number_o,
  output logic [2:0]        layer_number_o,
  output logic [2:0]        weight_number_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);

  state_t      state;
  logic        is_input;
  logic [3:0]  row;
  logic [2:0]  layer;
  logic [2:0]  beat;
  logic [31:0] payload_q;
  logic        last_read;

  // Read strobe is combinational so a stall blocks the read in the same cycle.
  always_comb begin
    mem_rd_en_o    = (state == RUN) && !stall_i;
    mem_rd_addr_o  = is_input ? ADDR_W'({row, beat})
                              : ADDR_W'({({1'b0, layer} + 4'd1), row, beat});
    last_read      = !is_input && (layer == LAST_LAYER) && (row == 4'd15) && (beat == 3'd7);
    load_payload_o = load_en_o ? mem_rd_data_i : payload_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      is_input            <= 1'b1;
      row                 <= '0;
      layer               <= '0;
      beat                <= '0;
      payload_q           <= '0;
      load_en_o           <= 1'b0;
      load_type_o         <= 1'b0;
      input_load_number_o <= '0;
      layer_number_o      <= '0;
      weight_number_o     <= '0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      load_en_o <= mem_rd_en_o;
      if (load_en_o) payload_q <= mem_rd_data_i;

      // Tags follow the issuing address; weight number is frozen during input beats.
      if (mem_rd_en_o) begin
        load_type_o         <= is_input;
        input_load_number_o <= row;
        layer_number_o      <= layer;
        if (!is_input) weight_number_o <= beat;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= RUN;
            busy_o   <= 1'b1;
            is_input <= 1'b1;
            row      <= '0;
            layer    <= '0;
            beat     <= '0;
          end
        end
        RUN: begin
          if (mem_rd_en_o) begin
            if (last_read) begin
              state <= DRAIN;
            end else if (beat != 3'd7) begin
              beat <= beat + 3'd1;
            end else begin
              beat <= '0;
              if (is_input) begin
                is_input <= 1'b0;
              end else if (row != 4'd15) begin
                row      <= row + 4'd1;
                is_input <= (layer == 3'd0);
              end else begin
                row   <= '0;
                layer <= layer + 3'd1;
              end
            end
          end
        end
        DRAIN: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
